// File: rtl/mem_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Any module that exchanges these types must use the same widths.
package mem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  // The memory port only understands doubleword addresses.
  function automatic logic [ADDR_W-1:0] dword_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(7);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit 0 = IFU, bit 1 = LSU.
// On a tie the requester that was not granted last time wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] valid_i,
  input  owner_e     last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == OWN_LSU) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the IFU and LSU, one transaction at a time,
// with round-robin arbitration and a response timeout.
module mem_arbiter #(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int DATA_W  = mem_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                lsu_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,

  output logic                busy
);

  import mem_pkg::*;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  mem_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ifu_data_q, ifu_data_d;
  logic [DATA_W-1:0] lsu_data_q, lsu_data_d;
  logic              ifu_err_q, ifu_err_d;
  logic              lsu_err_q, lsu_err_d;

  logic [1:0]        grant;
  logic              resp_load;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic [CNT_W-1:0]  cnt_inc;

  rr_arb2 u_rr_arb2 (
    .valid_i      ({lsu_req_valid, ifu_req_valid}),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  // Ready is offered only in IDLE and never while reset is held.
  assign ifu_req_ready = reset && (state_q == IDLE) && grant[0];
  assign lsu_req_ready = reset && (state_q == IDLE) && grant[1];

  assign cnt_inc = cnt_q + CNT_W'(1);

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    resp_load  = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ifu_req_ready && ifu_req_valid) begin
          req_d   = '{addr: dword_align(ifu_addr), wen: 1'b0, wdata: '0, wmask: '0};
          owner_d = OWN_IFU;
          last_d  = OWN_IFU;
          state_d = REQ;
        end else if (lsu_req_ready && lsu_req_valid) begin
          req_d   = '{addr: dword_align(lsu_addr), wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
          owner_d = OWN_LSU;
          last_d  = OWN_LSU;
          state_d = REQ;
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (mem_resp_valid) begin
          resp_load = 1'b1;
          resp_data = req_q.wen ? '0 : mem_resp_data;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            resp_load = 1'b1;
            resp_err  = 1'b1;
            state_d   = RESP;
          end
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each requester keeps its own copy so its outputs hold across the other's traffic.
  always_comb begin
    ifu_data_d = ifu_data_q;
    ifu_err_d  = ifu_err_q;
    lsu_data_d = lsu_data_q;
    lsu_err_d  = lsu_err_q;
    if (resp_load) begin
      if (owner_q == OWN_IFU) begin
        ifu_data_d = resp_data;
        ifu_err_d  = resp_err;
      end else begin
        lsu_data_d = resp_data;
        lsu_err_d  = resp_err;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the latched request and response registers are reset too, since their values are visible on ports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IFU;
      last_q     <= OWN_LSU;
      req_q      <= '0;
      cnt_q      <= '0;
      ifu_data_q <= '0;
      ifu_err_q  <= 1'b0;
      lsu_data_q <= '0;
      lsu_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      ifu_data_q <= ifu_data_d;
      ifu_err_q  <= ifu_err_d;
      lsu_data_q <= lsu_data_d;
      lsu_err_q  <= lsu_err_d;
    end
  end

  assign mem_req_valid  = (state_q == REQ);
  assign mem_addr       = req_q.addr;
  assign mem_wen        = req_q.wen;
  assign mem_wdata      = req_q.wdata;
  assign mem_wmask      = req_q.wmask;

  assign ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
  assign ifu_resp_data  = ifu_data_q;
  assign ifu_resp_err   = ifu_err_q;
  assign lsu_resp_data  = lsu_data_q;
  assign lsu_resp_err   = lsu_err_q;

  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model of arbitration order, request fields, latency and responses.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [63:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [63:0] lsu_addr;
  logic        lsu_wen;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [63:0] lsu_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who was granted last, and what each requester last received.
  bit          m_last_lsu;
  logic [63:0] m_ifu_data, m_lsu_data;
  bit          m_ifu_err, m_lsu_err;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_data  (ifu_resp_data),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_ifu_data"}, ifu_resp_data, m_ifu_data);
    check({tag, "_ifu_err"},  ifu_resp_err,  m_ifu_err);
    check({tag, "_lsu_data"}, lsu_resp_data, m_lsu_data);
    check({tag, "_lsu_err"},  lsu_resp_err,  m_lsu_err);
  endtask

  task automatic model_reset();
    m_last_lsu = 1'b1;
    m_ifu_data = '0;
    m_lsu_data = '0;
    m_ifu_err  = 1'b0;
    m_lsu_err  = 1'b0;
  endtask

  // One complete transaction. resp_dly = WAIT cycles before memory answers
  // (>= TO means it never answers); rst_at >= 0 pulls reset in that WAIT cycle.
  task automatic run_txn(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                         input bit wen, input logic [63:0] wd, input logic [7:0] wm,
                         input int req_dly, input int resp_dly, input logic [63:0] rdata,
                         input int rst_at);
    bit          win_lsu;
    logic [63:0] e_addr, e_wd, e_data;
    logic [7:0]  e_wm;
    bit          e_wen, e_err;
    int          n_idle;

    win_lsu = (iv && lv) ? !m_last_lsu : lv;
    if (win_lsu) begin
      e_addr = la & ~64'h7; e_wen = wen; e_wd = wd; e_wm = wm;
    end else begin
      e_addr = ia & ~64'h7; e_wen = 1'b0; e_wd = '0; e_wm = '0;
    end

    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    #1;
    check("ifu_ready_idle", ifu_req_ready, iv && !win_lsu);
    check("lsu_ready_idle", lsu_req_ready, lv && win_lsu);
    check("busy_idle", busy, 0);
    tick();
    m_last_lsu = win_lsu;

    // Requesters keep pushing different values; none of it may leak in.
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = {$urandom, $urandom}; lsu_addr = {$urandom, $urandom};
    lsu_wen = ~wen; lsu_wdata = ~wd; lsu_wmask = ~wm;

    for (int k = 0; k <= req_dly; k++) begin
      mem_req_ready = (k == req_dly);
      #1;
      check("req_valid", mem_req_valid, 1);
      check("req_addr",  mem_addr,  e_addr);
      check("req_wen",   mem_wen,   e_wen);
      check("req_wdata", mem_wdata, e_wd);
      check("req_wmask", mem_wmask, e_wm);
      check("req_ifu_ready", ifu_req_ready, 0);
      check("req_lsu_ready", lsu_req_ready, 0);
      check("req_busy", busy, 1);
      tick();
    end
    mem_req_ready = 1'b0;

    n_idle = (resp_dly < TO) ? resp_dly : TO;
    for (int k = 0; k < n_idle; k++) begin
      if (k == rst_at) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_busy", busy, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_ifu_resp", ifu_resp_valid, 0);
        check("rst_lsu_resp", lsu_resp_valid, 0);
        check_held("rst");
        tick();
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_lsu_ready", lsu_req_ready, 0);
        check("rst_busy_hold", busy, 0);
        #2;
        reset = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();
        check("rst_release_busy", busy, 0);
        check("rst_release_resp", ifu_resp_valid | lsu_resp_valid, 0);
        return;
      end
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = 1'b0;
      #1;
      check("wait_req_valid", mem_req_valid, 0);
      check("wait_ifu_resp", ifu_resp_valid, 0);
      check("wait_lsu_resp", lsu_resp_valid, 0);
      check("wait_busy", busy, 1);
      tick();
    end
    mem_req_ready = 1'b0;

    if (resp_dly < TO) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      tick();
      mem_resp_valid = 1'b0;
      e_data = (win_lsu && wen) ? 64'h0 : rdata;
      e_err  = 1'b0;
    end else begin
      e_data = '0;
      e_err  = 1'b1;
    end

    if (win_lsu) begin m_lsu_data = e_data; m_lsu_err = e_err; end
    else         begin m_ifu_data = e_data; m_ifu_err = e_err; end
    check("resp_ifu_valid", ifu_resp_valid, !win_lsu);
    check("resp_lsu_valid", lsu_resp_valid, win_lsu);
    check_held("resp");
    check("resp_ifu_ready", ifu_req_ready, 0);
    check("resp_lsu_ready", lsu_req_ready, 0);
    check("resp_busy", busy, 1);

    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();
    check("post_ifu_resp", ifu_resp_valid, 0);
    check("post_lsu_resp", lsu_resp_valid, 0);
    check("post_busy", busy, 0);
    check_held("post");
  endtask

  initial begin
    bit [1:0] pat;

    reset = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = '0;
    lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_reset();
    #3;
    check("reset_busy", busy, 0);
    check("reset_req_valid", mem_req_valid, 0);
    check("reset_ifu_ready", ifu_req_ready, 0);
    check("reset_lsu_ready", lsu_req_ready, 0);
    check("reset_resp_valid", ifu_resp_valid | lsu_resp_valid, 0);
    check_held("reset");
    @(posedge clock);
    @(posedge clock);
    #3;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Ties from reset alternate IFU, LSU, IFU.
    for (int i = 0; i < 3; i++)
      run_txn(1, 1, 64'h1000 + 64'(i * 8), 64'h2000 + 64'(i * 8), 1'b0, 64'h0, 8'h0,
              0, 0, 64'hA5A5_0000_0000_0000 + 64'(i), -1);

    run_txn(1, 0, 64'h8000_0004, 64'h0, 1'b0, 64'h0, 8'h0, 0, 0, 64'h1122334455667788, -1);
    run_txn(0, 1, 64'h0, 64'h8000_0010, 1'b1, 64'hDEADBEEF, 8'h0F, 0, 0, 64'hFFFF, -1);
    run_txn(1, 0, 64'h8000_0123, 64'h0, 1'b0, 64'h0, 8'h0, 5, 1, 64'h0BAD_F00D_CAFE_BEEF, -1);
    run_txn(0, 1, 64'h0, 64'h4000_0008, 1'b0, 64'h0, 8'hFF, 1, TO - 1, 64'h1234_5678_9ABC_DEF0, -1);
    run_txn(1, 0, 64'h9000_0000, 64'h0, 1'b0, 64'h0, 8'h0, 0, TO, 64'h0, -1);

    // A late memory answer in IDLE must not produce a pulse.
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h7777_7777_7777_7777;
    #1;
    check("late_resp_now", ifu_resp_valid | lsu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    check("late_resp_next", ifu_resp_valid | lsu_resp_valid, 0);
    check("late_busy", busy, 0);
    check_held("late");

    run_txn(0, 1, 64'h0, 64'h5000_0000, 1'b0, 64'h0, 8'h0, 0, TO, 64'h0, 3);
    run_txn(1, 1, 64'h6000_0000, 64'h6100_0000, 1'b0, 64'h0, 8'h0, 0, 0, 64'h600D, -1);

    for (int t = 0; t < 40; t++) begin
      pat = 2'($urandom_range(1, 3));
      run_txn(pat[0], pat[1], {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, TO + 1),
              {$urandom, $urandom}, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
